// File: rtl/dmem_map_pkg.sv
// Shared memory map for the data-memory responder: MMIO addresses, STATUS bit
// layout and the read-source selector used by the responder.
package dmem_map_pkg;

  localparam int MAP_ADDR_W = 12;

  localparam logic [MAP_ADDR_W-1:0] ADDR_CYCLE  = 12'hFFC;
  localparam logic [MAP_ADDR_W-1:0] ADDR_STATUS = 12'hFFD;
  localparam logic [MAP_ADDR_W-1:0] ADDR_TXDATA = 12'hFFE;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 3;

  // Source of the word that q_dmem will show after the next edge.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_CYCLE,
    SEL_STATUS
  } rd_sel_e;

endpackage

// File: rtl/tx_word_fifo.sv
// Word FIFO feeding the TX stream. A push into a full FIFO is only accepted
// when a pop frees a slot on the same edge; otherwise the caller sees it dropped.
module tx_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : store[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: synchronous RAM in the low range plus an MMIO page
// (cycle counter, status, TX FIFO) at the top of the 12-bit word space.
module dmem_mmio_responder
  import dmem_map_pkg::*;
#(
  parameter int RAM_DEPTH  = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q_dmem,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_overflow
);

  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [RAM_AW-1:0] ram_idx;
  logic              in_ram;
  logic              is_cycle;
  logic              is_status;
  logic              is_txdata;
  logic              wr_cycle;
  logic              wr_status;
  logic              wr_txdata;

  logic [DATA_W-1:0] cycle_q;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] mmio_d;
  logic [DATA_W-1:0] mmio_q;
  rd_sel_e           rd_sel;
  rd_sel_e           sel_q;

  logic              pop_req;
  logic              ovf_set;
  logic              ovf_clr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  assign in_ram    = (address_dmem < ADDR_W'(RAM_DEPTH));
  assign ram_idx   = address_dmem[RAM_AW-1:0];
  assign is_cycle  = (address_dmem == ADDR_W'(ADDR_CYCLE));
  assign is_status = (address_dmem == ADDR_W'(ADDR_STATUS));
  assign is_txdata = (address_dmem == ADDR_W'(ADDR_TXDATA));

  assign wr_cycle  = wren & is_cycle;
  assign wr_status = wren & is_status;
  assign wr_txdata = wren & is_txdata;

  assign tx_valid  = ~fifo_empty;
  assign pop_req   = tx_valid & tx_ready;
  assign ovf_set   = wr_txdata & fifo_full & ~pop_req;
  assign ovf_clr   = wr_status & data[ST_OVF];

  tx_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_txdata),
    .push_data (data),
    .pop       (pop_req),
    .head      (tx_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // RAM is read-first: a load and store to the same word return the old value.
  always_ff @(posedge clock) begin
    if (!reset && wren && in_ram) begin
      ram[ram_idx] <= data;
    end
    ram_q <= ram[ram_idx];
  end

  always_comb begin
    status_word                         = '0;
    status_word[ST_EMPTY]               = fifo_empty;
    status_word[ST_FULL]                = fifo_full;
    status_word[ST_OVF]                 = tx_overflow;
    status_word[ST_CNT_LSB +: CNT_W]    = fifo_count;
  end

  always_comb begin
    rd_sel = SEL_NONE;
    if (in_ram) begin
      rd_sel = SEL_RAM;
    end else if (is_cycle) begin
      rd_sel = SEL_CYCLE;
    end else if (is_status) begin
      rd_sel = SEL_STATUS;
    end
  end

  always_comb begin
    mmio_d = '0;
    case (rd_sel)
      SEL_CYCLE:  mmio_d = cycle_q;
      SEL_STATUS: mmio_d = status_word;
      default:    mmio_d = '0;
    endcase
  end

  // MMIO values are captured alongside the RAM read so both share one cycle of latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q  <= SEL_NONE;
      mmio_q <= '0;
    end else begin
      sel_q  <= rd_sel;
      mmio_q <= mmio_d;
    end
  end

  assign q_dmem = (sel_q == SEL_RAM) ? ram_q : mmio_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q <= '0;
    end else if (wr_cycle) begin
      cycle_q <= data;
    end else begin
      cycle_q <= cycle_q + ONE;
    end
  end

  // A drop on the same edge as a software clear leaves the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_overflow <= 1'b0;
    end else if (ovf_set) begin
      tx_overflow <= 1'b1;
    end else if (ovf_clr) begin
      tx_overflow <= 1'b0;
    end
  end

endmodule
